hazard_scoreboard: RTL and testbench

- Sequential hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the per-instruction register addresses and Tuse/Tnew produced in ID.
- Keeps a shadow scoreboard of the instructions in flight in E, M and W.
- Drives stall/flush enables and the forwarding-mux selects for D, E and M consumers.

---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Stall/flush and forwarding controller for a 5-stage MIPS pipeline
//
// Optional mult/div busy interlock: define HS_MULDIV_EN.
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RA1_ID,
    input  logic [4:0] RA2_ID,
    input  logic [4:0] WA_ID,
    input  logic [1:0] Tuse_RA1,
    input  logic [1:0] Tuse_RA2,
    input  logic [1:0] Tnew_ID,
    output logic       stall,
    output logic       en_PC,
    output logic       en_FD,
    output logic       flush_DE,
    output logic [1:0] fwd_D_rs,
    output logic [1:0] fwd_D_rt,
    output logic [1:0] fwd_E_rs,
    output logic [1:0] fwd_E_rt,
    output logic       fwd_M_rt
`ifdef HS_MULDIV_EN
    ,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       md_use_ID,
    output logic       md_busy
`endif
);

    // Shadow records of the instructions sitting in E, M and W.
    // Tnew is the number of cycles left until the result exists.
    logic [4:0] r_wa_e;
    logic [1:0] r_tnew_e;
    logic [4:0] r_ra1_e;
    logic [4:0] r_ra2_e;

    logic [4:0] r_wa_m;
    logic [1:0] r_tnew_m;
    logic [4:0] r_ra2_m;

    logic [4:0] r_wa_w;
    logic [1:0] r_tnew_w;

    logic       w_stall_haz;
    logic       w_stall_md;
    logic       w_stall;
    logic [1:0] w_tnew_id;
    logic [1:0] w_tnew_e_dec;
    logic [1:0] w_tnew_m_dec;

    // A source hits a producer only when it is a real register and the addresses agree.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] wa);
        return (src != 5'd0) && (src == wa);
    endfunction

    // Decrement the remaining latency, never wrapping below zero.
    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // D consumer select: youngest ready producer wins (E, then M, then W).
    function automatic logic [1:0] sel_d(
        input logic [4:0] src,
        input logic [4:0] wa_e, input logic [1:0] tn_e,
        input logic [4:0] wa_m, input logic [1:0] tn_m,
        input logic [4:0] wa_w, input logic [1:0] tn_w
    );
        logic [1:0] s;
        s = 2'd0;
        if (hit(src, wa_e) && tn_e == 2'd0)      s = 2'd1;
        else if (hit(src, wa_m) && tn_m == 2'd0) s = 2'd2;
        else if (hit(src, wa_w) && tn_w == 2'd0) s = 2'd3;
        return s;
    endfunction

    // E consumer select: M result preferred over the W result.
    function automatic logic [1:0] sel_e(
        input logic [4:0] src,
        input logic [4:0] wa_m, input logic [1:0] tn_m,
        input logic [4:0] wa_w, input logic [1:0] tn_w
    );
        logic [1:0] s;
        s = 2'd0;
        if (hit(src, wa_m) && tn_m == 2'd0)      s = 2'd1;
        else if (hit(src, wa_w) && tn_w == 2'd0) s = 2'd2;
        return s;
    endfunction

    // An instruction that writes no register carries no latency, so it can never match.
    assign w_tnew_id    = (WA_ID == 5'd0) ? 2'd0 : Tnew_ID;
    assign w_tnew_e_dec = dec_sat(r_tnew_e);
    assign w_tnew_m_dec = dec_sat(r_tnew_m);

    // Stall when a producer in E or M cannot deliver before the D consumer needs it.
    always_comb begin
        w_stall_haz = 1'b0;
        if (hit(RA1_ID, r_wa_e) && (r_tnew_e > Tuse_RA1)) w_stall_haz = 1'b1;
        if (hit(RA1_ID, r_wa_m) && (r_tnew_m > Tuse_RA1)) w_stall_haz = 1'b1;
        if (hit(RA2_ID, r_wa_e) && (r_tnew_e > Tuse_RA2)) w_stall_haz = 1'b1;
        if (hit(RA2_ID, r_wa_m) && (r_tnew_m > Tuse_RA2)) w_stall_haz = 1'b1;
    end

`ifdef HS_MULDIV_EN
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [MD_W-1:0] r_md_cnt;

    // Busy countdown for the iterative multiplier/divider; a new issue reloads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start_E) begin
            r_md_cnt <= md_is_div_E ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_stall_md = md_use_ID && (md_busy || md_start_E);
`else
    assign w_stall_md = 1'b0;
`endif

    assign w_stall  = w_stall_haz || w_stall_md;
    assign stall    = w_stall;
    assign en_PC    = ~w_stall;
    assign en_FD    = ~w_stall;
    assign flush_DE = w_stall;

    // Forwarding selects for the D, E and M consumers.
    always_comb begin
        fwd_D_rs = sel_d(RA1_ID, r_wa_e, r_tnew_e, r_wa_m, r_tnew_m, r_wa_w, r_tnew_w);
        fwd_D_rt = sel_d(RA2_ID, r_wa_e, r_tnew_e, r_wa_m, r_tnew_m, r_wa_w, r_tnew_w);
        fwd_E_rs = sel_e(r_ra1_e, r_wa_m, r_tnew_m, r_wa_w, r_tnew_w);
        fwd_E_rt = sel_e(r_ra2_e, r_wa_m, r_tnew_m, r_wa_w, r_tnew_w);
        fwd_M_rt = hit(r_ra2_m, r_wa_w);
    end

    // Advance the scoreboard every cycle; a stall injects a bubble into E.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wa_e   <= 5'd0;
            r_tnew_e <= 2'd0;
            r_ra1_e  <= 5'd0;
            r_ra2_e  <= 5'd0;
            r_wa_m   <= 5'd0;
            r_tnew_m <= 2'd0;
            r_ra2_m  <= 5'd0;
            r_wa_w   <= 5'd0;
            r_tnew_w <= 2'd0;
        end else begin
            if (w_stall) begin
                r_wa_e   <= 5'd0;
                r_tnew_e <= 2'd0;
                r_ra1_e  <= 5'd0;
                r_ra2_e  <= 5'd0;
            end else begin
                r_wa_e   <= WA_ID;
                r_tnew_e <= w_tnew_id;
                r_ra1_e  <= RA1_ID;
                r_ra2_e  <= RA2_ID;
            end
            r_wa_m   <= r_wa_e;
            r_tnew_m <= w_tnew_e_dec;
            r_ra2_m  <= r_ra2_e;
            r_wa_w   <= r_wa_m;
            r_tnew_w <= w_tnew_m_dec;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - Self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RA1_ID, RA2_ID, WA_ID;
    logic [1:0] Tuse_RA1, Tuse_RA2, Tnew_ID;
    logic       stall, en_PC, en_FD, flush_DE;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic       fwd_M_rt;
`ifdef HS_MULDIV_EN
    logic       md_start_E, md_is_div_E, md_use_ID, md_busy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .RA1_ID   (RA1_ID),
        .RA2_ID   (RA2_ID),
        .WA_ID    (WA_ID),
        .Tuse_RA1 (Tuse_RA1),
        .Tuse_RA2 (Tuse_RA2),
        .Tnew_ID  (Tnew_ID),
        .stall    (stall),
        .en_PC    (en_PC),
        .en_FD    (en_FD),
        .flush_DE (flush_DE),
        .fwd_D_rs (fwd_D_rs),
        .fwd_D_rt (fwd_D_rt),
        .fwd_E_rs (fwd_E_rs),
        .fwd_E_rt (fwd_E_rt),
        .fwd_M_rt (fwd_M_rt)
`ifdef HS_MULDIV_EN
        ,
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .md_use_ID   (md_use_ID),
        .md_busy     (md_busy)
`endif
    );

    // Reference model: the last three instructions that entered E, youngest first
    // (0 = E, 1 = M, 2 = W). Each keeps the latency it had on entering E; the
    // remaining latency is derived from how far it has travelled since.
    typedef struct {
        int wa;
        int tnew;
        int ra1;
        int ra2;
    } rec_t;

    rec_t hist[3];

    function automatic int remaining(int k);
        int r;
        r = hist[k].tnew - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit produces(int src, int k);
        return (src != 0) && (src == hist[k].wa);
    endfunction

    function automatic bit model_stall();
        bit s;
        s = 0;
        for (int k = 0; k < 2; k++) begin
            if (produces(int'(RA1_ID), k) && remaining(k) > int'(Tuse_RA1)) s = 1;
            if (produces(int'(RA2_ID), k) && remaining(k) > int'(Tuse_RA2)) s = 1;
        end
        return s;
    endfunction

    function automatic int model_fwd_d(int src);
        for (int k = 0; k < 3; k++)
            if (produces(src, k) && remaining(k) == 0) return k + 1;
        return 0;
    endfunction

    function automatic int model_fwd_e(int src);
        for (int k = 1; k < 3; k++)
            if (produces(src, k) && remaining(k) == 0) return k;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit st;
        st = model_stall();
        if (reset) begin
            for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (st) hist[0] = '{0, 0, 0, 0};
            else    hist[0] = '{int'(WA_ID), (WA_ID == 0) ? 0 : int'(Tnew_ID),
                                int'(RA1_ID), int'(RA2_ID)};
        end
    end

    task automatic set_id(input int ra1, input int ra2, input int wa,
                          input int tu1, input int tu2, input int tn);
        RA1_ID   = 5'(ra1);
        RA2_ID   = 5'(ra2);
        WA_ID    = 5'(wa);
        Tuse_RA1 = 2'(tu1);
        Tuse_RA2 = 2'(tu2);
        Tnew_ID  = 2'(tn);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        checks++; if (en_PC !== 1'b1)    begin errors++; $display("FAIL reset_en_PC got %0b exp 1", en_PC); end
        checks++; if (en_FD !== 1'b1)    begin errors++; $display("FAIL reset_en_FD got %0b exp 1", en_FD); end
        checks++; if (flush_DE !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", flush_DE); end
        checks++;
        if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt} !== 9'd0) begin
            errors++; $display("FAIL reset_fwd got %0h exp 0", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 9, 1, 1, 2);              // lw $9, 0($1)
        step();
        set_id(9, 2, 10, 1, 1, 1);             // add $10, $9, $2
        #1;
        checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL lu_stall1 got %0b exp 1", stall); end
        checks++; if (en_PC !== 1'b0)    begin errors++; $display("FAIL lu_en_PC got %0b exp 0", en_PC); end
        checks++; if (flush_DE !== 1'b1) begin errors++; $display("FAIL lu_flush got %0b exp 1", flush_DE); end
        step();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %0b exp 0", stall); end
        step();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (fwd_E_rs !== 2'd2) begin errors++; $display("FAIL lu_fwd_E_rs got %0d exp 2", fwd_E_rs); end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 2, 8, 1, 1, 1);              // add $8, $1, $2
        step();
        set_id(8, 0, 0, 0, 0, 0);              // beq $8, $0
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall1 got %0b exp 1", stall); end
        step();
        #1;
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL br_stall2 got %0b exp 0", stall); end
        checks++; if (fwd_D_rs !== 2'd2) begin errors++; $display("FAIL br_fwd_D_rs got %0d exp 2", fwd_D_rs); end
    endtask

    task automatic test_jal_jr();
        do_reset();
        set_id(0, 0, 31, 0, 0, 0);             // jal
        step();
        set_id(31, 0, 0, 0, 0, 0);             // jr $31
        #1;
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL jr_stall got %0b exp 0", stall); end
        checks++; if (fwd_D_rs !== 2'd1) begin errors++; $display("FAIL jr_fwd_D_rs got %0d exp 1", fwd_D_rs); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_id(0, 0, 0, 0, 0, 2);          // writer to $0 with non-zero latency
            step();
        end
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %0b exp 0", stall); end
        checks++;
        if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt} !== 9'd0) begin
            errors++; $display("FAIL zero_fwd got %0h exp 0", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(0, 0, 5, 0, 0, 0);
        step();
        set_id(0, 0, 5, 0, 0, 0);
        step();
        set_id(5, 5, 0, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL b2b_stall got %0b exp 0", stall); end
        checks++; if (fwd_D_rs !== 2'd1) begin errors++; $display("FAIL b2b_fwd_D_rs got %0d exp 1", fwd_D_rs); end
        checks++; if (fwd_D_rt !== 2'd1) begin errors++; $display("FAIL b2b_fwd_D_rt got %0d exp 1", fwd_D_rt); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 0, 9, 1, 1, 2);
        step();
        set_id(9, 2, 10, 1, 1, 1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre got %0b exp 1", stall); end
        reset = 1'b1;
        step();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall got %0b exp 0", stall); end
        checks++;
        if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt} !== 9'd0) begin
            errors++; $display("FAIL rms_fwd got %0h exp 0", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt});
        end
        checks++;
        if ({dut.r_wa_e, dut.r_wa_m, dut.r_wa_w} !== 15'd0) begin
            errors++; $display("FAIL rms_board got %0h exp 0", {dut.r_wa_e, dut.r_wa_m, dut.r_wa_w});
        end
        reset = 1'b0;
    endtask

`ifdef HS_MULDIV_EN
    task automatic test_muldiv();
        int busy_cycles;
        do_reset();
        md_start_E  = 1'b1;
        md_is_div_E = 1'b1;
        md_use_ID   = 1'b1;                    // mflo in D
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_start_stall got %0b exp 1", stall); end
        step();
        md_start_E  = 1'b0;
        md_is_div_E = 1'b0;
        busy_cycles = 0;
        #1;
        while (md_busy === 1'b1 && busy_cycles < 50) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_hold got %0b exp 1", stall); end
            busy_cycles++;
            step();
            #1;
        end
        checks++; if (busy_cycles != 10) begin errors++; $display("FAIL md_cycles got %0d exp 10", busy_cycles); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL md_release got %0b exp 0", stall); end
        md_use_ID = 1'b0;
    endtask
`endif

    task automatic test_random();
        int e_stall, e_d_rs, e_d_rt, e_e_rs, e_e_rt, e_m_rt;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            #1;
            e_stall = int'(model_stall());
            e_d_rs  = model_fwd_d(int'(RA1_ID));
            e_d_rt  = model_fwd_d(int'(RA2_ID));
            e_e_rs  = model_fwd_e(hist[0].ra1);
            e_e_rt  = model_fwd_e(hist[0].ra2);
            e_m_rt  = int'(produces(hist[1].ra2, 2));
            checks++; if (int'(stall) != e_stall)    begin errors++; $display("FAIL rnd_stall n=%0d got %0b exp %0d", n, stall, e_stall); end
            checks++; if (int'(en_PC) != 1 - e_stall) begin errors++; $display("FAIL rnd_en_PC n=%0d got %0b exp %0d", n, en_PC, 1 - e_stall); end
            checks++; if (int'(en_FD) != 1 - e_stall) begin errors++; $display("FAIL rnd_en_FD n=%0d got %0b exp %0d", n, en_FD, 1 - e_stall); end
            checks++; if (int'(flush_DE) != e_stall) begin errors++; $display("FAIL rnd_flush n=%0d got %0b exp %0d", n, flush_DE, e_stall); end
            checks++; if (int'(fwd_D_rs) != e_d_rs)  begin errors++; $display("FAIL rnd_fwd_D_rs n=%0d got %0d exp %0d", n, fwd_D_rs, e_d_rs); end
            checks++; if (int'(fwd_D_rt) != e_d_rt)  begin errors++; $display("FAIL rnd_fwd_D_rt n=%0d got %0d exp %0d", n, fwd_D_rt, e_d_rt); end
            checks++; if (int'(fwd_E_rs) != e_e_rs)  begin errors++; $display("FAIL rnd_fwd_E_rs n=%0d got %0d exp %0d", n, fwd_E_rs, e_e_rs); end
            checks++; if (int'(fwd_E_rt) != e_e_rt)  begin errors++; $display("FAIL rnd_fwd_E_rt n=%0d got %0d exp %0d", n, fwd_E_rt, e_e_rt); end
            checks++; if (int'(fwd_M_rt) != e_m_rt)  begin errors++; $display("FAIL rnd_fwd_M_rt n=%0d got %0b exp %0d", n, fwd_M_rt, e_m_rt); end
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
`ifdef HS_MULDIV_EN
        md_start_E  = 1'b0;
        md_is_div_E = 1'b0;
        md_use_ID   = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_reg_zero();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef HS_MULDIV_EN
        test_muldiv();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
